// File: rtl/cdb_arb.sv
// cdb_arb: round-robin arbiter for the common data bus (CDB).
// Execution units raise req with a result tag and data. One requester is
// granted per cycle, combinationally. The winner's tag and data go out on
// the bus. Tag 0 means "no dependency" and is never broadcast. A request
// carrying tag 0 is still granted, so the requester is freed, but it only
// sets the sticky err_tag0 flag.
//
// Handshake: request i completes in the cycle where req[i] && gnt[i] is
// true at the rising clock edge. A requester holds req, req_tag and
// req_wdata stable until that cycle. It may withdraw req before it is
// granted; a withdrawn request is never broadcast.
//
// Optional build macro CDB_ARB_OUT_REG_EN: registers cdb_wr, cdb_tag and
// cdb_wdata, so the broadcast appears one cycle after the grant cycle.
// Without the macro the bus is driven combinationally in the grant cycle.
// Grant timing and pointer behaviour are the same in both builds.
module cdb_arb #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic                    cdb_wr,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_wdata,
  output logic                    err_tag0
);

  localparam int PTR_W = $clog2(N_REQ);

  // Priority pointer: the requester searched first. Always < N_REQ.
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              err_tag0_q, err_tag0_d;

  // Arbitration results for the current cycle
  logic [N_REQ-1:0]  gnt_c;
  logic              gnt_any;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  cand;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  // Broadcast the winner would produce this cycle
  logic              bc_wr;
  logic [TAG_W-1:0]  bc_tag;
  logic [DATA_W-1:0] bc_data;

  // Round-robin search from ptr_q, wrapping at N_REQ-1; gated off during reset
  always_comb begin
    gnt_c   = '0;
    gnt_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = PTR_W'((int'(ptr_q) + off) % N_REQ);
      if (!gnt_any && !rst && req[cand]) begin
        gnt_any     = 1'b1;
        gnt_c[cand] = 1'b1;
        win_idx     = cand;
      end
    end
  end

  // One-hot AND-OR mux of the winner's tag and data
  always_comb begin
    win_tag  = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_tag  = win_tag  | (req_tag[i*TAG_W +: TAG_W]     & {TAG_W{gnt_c[i]}});
      win_data = win_data | (req_wdata[i*DATA_W +: DATA_W] & {DATA_W{gnt_c[i]}});
    end
  end

  // Broadcast value, pointer advance and sticky tag-0 flag
  always_comb begin
    bc_wr      = gnt_any && (win_tag != '0);
    bc_tag     = bc_wr ? win_tag  : '0;
    bc_data    = bc_wr ? win_data : '0;
    err_tag0_d = err_tag0_q || (gnt_any && (win_tag == '0));
    ptr_d      = ptr_q;
    if (gnt_any) begin
      ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Pointer and error flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      err_tag0_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      err_tag0_q <= err_tag0_d;
    end
  end

  assign gnt      = gnt_c;
  assign err_tag0 = err_tag0_q;

`ifdef CDB_ARB_OUT_REG_EN
  logic              cdb_wr_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_wdata_q;

  // Registered bus: the broadcast follows the grant cycle; reset drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_wr_q    <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_wdata_q <= '0;
    end else begin
      cdb_wr_q    <= bc_wr;
      cdb_tag_q   <= bc_tag;
      cdb_wdata_q <= bc_data;
    end
  end

  assign cdb_wr    = cdb_wr_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_wdata = cdb_wdata_q;
`else
  assign cdb_wr    = bc_wr;
  assign cdb_tag   = bc_tag;
  assign cdb_wdata = bc_data;
`endif

endmodule

// File: doc/cdb_arb.md
CDB_ARB -- requirements
Module: cdb_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of execution-unit requesters (2..8).
REQ-002 SHALL have parameter TAG_W, default 4: broadcast tag width.
REQ-003 SHALL have parameter DATA_W, default 32: broadcast data width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  in  N_REQ  per-requester broadcast request.
REQ-007 SHALL have port req_tag  in  N_REQ*TAG_W  per-requester result tag; requester i at bits [i*TAG_W +: TAG_W].
REQ-008 SHALL have port req_wdata  in  N_REQ*DATA_W  per-requester result data, same packing.
REQ-009 SHALL have port gnt  out  N_REQ  one-hot grant; request i completes in the cycle req[i] && gnt[i].
REQ-010 SHALL have port cdb_wr  out  1  common data bus write strobe.
REQ-011 SHALL have port cdb_tag  out  TAG_W  broadcast tag.
REQ-012 SHALL have port cdb_wdata  out  DATA_W  broadcast data.
REQ-013 SHALL have port err_tag0  out  1  sticky flag: a request carried reserved tag 0.

Function
REQ-014 SHALL assert at most one gnt bit per cycle, and only for a requester with req high.
REQ-015 SHALL derive gnt combinationally in the same cycle as req (zero-cycle grant).
REQ-016 SHALL arbitrate round-robin: search starts at priority pointer ptr (PTR_W = $clog2(N_REQ) bits) and wraps from N_REQ-1 to 0.
REQ-017 SHALL, on a grant to requester k, load ptr with (k+1) mod N_REQ; ptr SHALL hold when no grant occurs.
REQ-018 SHALL grant any continuously asserted request within N_REQ cycles (no starvation).
REQ-019 SHALL require a requester to hold req, req_tag and req_wdata stable until granted; withdrawing req before grant is legal and causes no broadcast.
REQ-020 SHALL never broadcast tag 0, which consumers treat as "no dependency".
REQ-021 SHALL grant a request whose tag is 0 (to free the requester) but suppress cdb_wr for it and set err_tag0.
REQ-022 SHALL hold err_tag0 at 1 until reset.
REQ-023 SHALL drive cdb_tag and cdb_wdata to 0 in any cycle cdb_wr is 0.
REQ-024 SHALL, for non-power-of-two N_REQ, never let ptr hold a value >= N_REQ.

Reset
REQ-025 SHALL, while rst is high, force gnt=0, cdb_wr=0, cdb_tag=0, cdb_wdata=0, ptr=0, err_tag0=0 immediately, independent of clk.
REQ-026 SHALL drop any pending or in-flight broadcast on reset; requesters re-present after rst deasserts.
REQ-027 SHALL give requester 0 highest priority in the first arbitrated cycle after reset.

Configuration
REQ-028 SHALL support macro CDB_ARB_OUT_REG_EN.
REQ-029 SHALL, with CDB_ARB_OUT_REG_EN defined, register cdb_wr/cdb_tag/cdb_wdata, so the broadcast appears exactly one cycle after the grant cycle and the bus is registered-driven.
REQ-030 SHALL, without CDB_ARB_OUT_REG_EN, drive cdb_wr/cdb_tag/cdb_wdata combinationally from the winning requester in the grant cycle.
REQ-031 SHALL keep grant timing and ptr behaviour identical in both configurations.

Verification
REQ-032 SHALL cover single request: after reset, req=0010, tag1=5, data1=0xDEADBEEF -> gnt=0010 same cycle; cdb_wr=1, tag=5, wdata=0xDEADBEEF (same cycle without macro, next cycle with it).
REQ-033 SHALL cover round-robin: req=1111 held 4 cycles with each granted requester dropping req after its grant -> grant order 0,1,2,3.
REQ-034 SHALL cover fairness and wrap: ptr=3, req=1001 -> gnt=1000; next cycle req=1001 -> gnt=0001.
REQ-035 SHALL cover tag 0: req=0100 with tag2=0 -> gnt=0100, cdb_wr=0, err_tag0=1 and remaining 1 for 10 cycles.
REQ-036 SHALL cover async reset: rst asserted mid-cycle during a grant to requester 2 -> gnt, cdb_wr and err_tag0 go 0 before the next clk edge; first grant after release with req=1111 is requester 0.
REQ-037 SHALL cover N_REQ=3 with req=111 held for 9 cycles -> each requester granted 3 times, ptr never equals 3.
